// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state
// encodings and the default operand width, which the ripple-adder bench
// also uses so both sides agree on operand layout.
package serial_arith_pkg;

  // Operand/result width used when the instantiating code gives none.
  localparam int DEFAULT_WIDTH = 3;

  // Sequencer states for the serial subtractor.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : serial_arith_pkg

// File: rtl/serial_subtractor_bit_sub_cell.sv
// bit_sub_cell: combinational 1-bit full subtractor (a - b - bin).
// When SERIAL_SUB_ADD_MODE_EN is defined the cell gains a 'mode' input.
// mode=1 turns it into a full adder, with bout carrying the carry-out.
module bit_sub_cell
  import serial_arith_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic mode,
`endif
  output logic d,
  output logic bout
);

  logic sub_bout;

  // The sum/difference bit is the same XOR for both add and subtract.
  assign d = a ^ b ^ bin;

  // A borrow is needed when b exceeds a, or when they are equal and a borrow
  // is already pending.
  assign sub_bout = (~a & b) | (~(a ^ b) & bin);

`ifdef SERIAL_SUB_ADD_MODE_EN
  logic add_cout;

  // The carry for addition is the majority of the three inputs.
  assign add_cout = (a & b) | (a & bin) | (b & bin);
  assign bout     = mode ? add_cout : sub_bout;
`else
  assign bout = sub_bout;
`endif

endmodule : bit_sub_cell

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial, multi-cycle a - b - borrow_in, LSB first,
// WIDTH cycles per operation with a start/ready/done handshake.
// Optional macro SERIAL_SUB_ADD_MODE_EN adds an add_mode input that selects
// a + b + borrow_in instead. In that mode borrow_out carries the carry-out.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic             add_mode,
`endif
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  // The counter must be able to hold WIDTH. It is derived from WIDTH so
  // that it cannot be set independently.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic             cell_d;
  logic             cell_bout;
  logic [WIDTH-1:0] res_next;

`ifdef SERIAL_SUB_ADD_MODE_EN
  logic             mode_r;
`endif

  // One full-subtractor slice handles the current LSB of both operands.
  bit_sub_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
`ifdef SERIAL_SUB_ADD_MODE_EN
    .mode (mode_r),
`endif
    .d    (cell_d),
    .bout (cell_bout)
  );

  // The new bit enters at the MSB. After WIDTH shifts, the first bit computed
  // has reached bit 0.
  assign res_next = {cell_d, res_sr[WIDTH-1:1]};

  // Sequencer, datapath shift registers, and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      ready      <= 1'b1;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
      mode_r     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= borrow_in;
            cnt   <= '0;
            ready <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            mode_r <= add_mode;
`endif
            state <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          br     <= cell_bout;
          res_sr <= res_next;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            diff       <= res_next;
            borrow_out <= cell_bout;
            done       <= 1'b1;
            state      <= ST_DONE;
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end

        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : serial_subtractor
